rc4_host_bridge: RTL and testbench

Byte-stream bridge between the host link and the RC4 cipher core. It buffers a 32-byte key and a plaintext message, then drives the core's key, plaintext and ciphertext ports. It captures the core's ciphertext and recovered plaintext and reports a round-trip mismatch count. It sits directly upstream and downstream of the RC4 core and owns all of that core's data-side handshakes.

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/rc4_byte_buf.sv | 35 +++
 rtl/rc4_host_bridge.sv | 195 +++++++++++++++++++
 tb/tb_rc4_host_bridge.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 bridge and core: sizes, byte type, state encoding.
package rc4_pkg;

  localparam int KEY_LEN = 32;
  localparam int MSG_MAX = 64;

  localparam int KEY_AW = $clog2(KEY_LEN);
  localparam int MSG_AW = $clog2(MSG_MAX);
  localparam int CNT_W  = MSG_AW + 1;

  typedef logic [7:0]       byte_t;
  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [KEY_AW:0]  kcnt_t;

  localparam kcnt_t KEY_LAST = kcnt_t'(KEY_LEN - 1);
  localparam cnt_t  MSG_FULL = cnt_t'(MSG_MAX);

  typedef enum logic [2:0] {
    IDLE,
    LOAD_KEY,
    LOAD_MSG,
    SEND_KEY,
    RUN,
    REPORT
  } state_t;

endpackage

// File: rtl/rc4_byte_buf.sv
// Byte RAM with one synchronous write port and NRD asynchronous read ports.
module rc4_byte_buf
  import rc4_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int NRD   = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  byte_t         wdata,
  input  logic [AW-1:0] raddr [NRD],
  output byte_t         rdata [NRD]
);

  byte_t mem [DEPTH];

  // Write port: one byte per cycle when we is high.
  // NOTE: the storage array has no reset; contents survive rst and only
  // bytes below the live length/pointer values are ever consumed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read ports: zero-latency lookups of the addressed bytes.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rdata[i] = mem[raddr[i]];
    end
  end

endmodule

// File: rtl/rc4_host_bridge.sv
// Host-link to RC4-core bridge: buffers key and message, feeds the core,
// captures ciphertext, and counts round-trip mismatches.
module rc4_host_bridge
  import rc4_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       host_valid,
  input  logic [7:0] host_data,
  input  logic       host_last,
  output logic       host_ready,
  output logic       key_valid,
  output logic [7:0] key_in,
  input  logic       plain_read,
  output logic       plain_in_valid,
  output logic [7:0] plain_in,
  input  logic       cipher_write,
  input  logic [7:0] cipher_out,
  input  logic       cipher_read,
  output logic       cipher_in_valid,
  output logic [7:0] cipher_in,
  input  logic       plain_write,
  input  logic [7:0] plain_out,
  input  logic       done,
  output logic       busy,
  output logic       finish,
  output logic       overflow,
  output logic [6:0] msg_len,
  output logic [6:0] mismatch_cnt
);

  state_t state, state_nxt;
  kcnt_t  key_cnt;
  cnt_t   len_q, p_ptr, c_ptr, mis_q;
  logic   ovf_q, finish_q;

  logic host_acc, start_acc, p_avail, c_avail, cw_acc, pw_acc, msg_room;

  // plain_read and cipher_read only announce intent; the pointers move on
  // the matching write strobes, so the data stays stable in between.
  logic unused_reads;
  assign unused_reads = plain_read ^ cipher_read;

  assign host_acc  = host_valid && host_ready;
  assign start_acc = host_acc && (state == IDLE || state == REPORT);
  assign msg_room  = len_q < MSG_FULL;
  assign p_avail   = p_ptr < len_q;
  assign c_avail   = c_ptr < p_ptr;
  assign cw_acc    = (state == RUN) && cipher_write && p_avail;
  assign pw_acc    = (state == RUN) && plain_write && c_avail;

  // Key store: byte 0 lands on the session-start accept, the rest in LOAD_KEY.
  logic              key_we;
  logic [KEY_AW-1:0] key_waddr;
  logic [KEY_AW-1:0] key_raddr [1];
  byte_t             key_rdata [1];

  assign key_we       = start_acc || (host_acc && state == LOAD_KEY);
  assign key_waddr    = start_acc ? '0 : key_cnt[KEY_AW-1:0];
  assign key_raddr[0] = key_cnt[KEY_AW-1:0];

  rc4_byte_buf #(.DEPTH(KEY_LEN), .NRD(1)) u_key_buf (
    .clk   (clk),
    .we    (key_we),
    .waddr (key_waddr),
    .wdata (host_data),
    .raddr (key_raddr),
    .rdata (key_rdata)
  );

  // Plaintext store: port 0 feeds the core, port 1 is the compare reference.
  logic              pbuf_we;
  logic [MSG_AW-1:0] pbuf_raddr [2];
  byte_t             pbuf_rdata [2];

  assign pbuf_we       = host_acc && (state == LOAD_MSG) && msg_room;
  assign pbuf_raddr[0] = p_ptr[MSG_AW-1:0];
  assign pbuf_raddr[1] = c_ptr[MSG_AW-1:0];

  rc4_byte_buf #(.DEPTH(MSG_MAX), .NRD(2)) u_pbuf (
    .clk   (clk),
    .we    (pbuf_we),
    .waddr (len_q[MSG_AW-1:0]),
    .wdata (host_data),
    .raddr (pbuf_raddr),
    .rdata (pbuf_rdata)
  );

  // Ciphertext store: written at p_ptr by the core, read back at c_ptr.
  logic [MSG_AW-1:0] cbuf_raddr [1];
  byte_t             cbuf_rdata [1];

  assign cbuf_raddr[0] = c_ptr[MSG_AW-1:0];

  rc4_byte_buf #(.DEPTH(MSG_MAX), .NRD(1)) u_cbuf (
    .clk   (clk),
    .we    (cw_acc),
    .waddr (p_ptr[MSG_AW-1:0]),
    .wdata (cipher_out),
    .raddr (cbuf_raddr),
    .rdata (cbuf_rdata)
  );

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  // NOTE: state_nxt gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, REPORT: if (host_acc) state_nxt = LOAD_KEY;
      LOAD_KEY:     if (host_acc && key_cnt == KEY_LAST) state_nxt = LOAD_MSG;
      LOAD_MSG:     if (host_acc && host_last) state_nxt = SEND_KEY;
      SEND_KEY:     if (key_cnt == KEY_LAST) state_nxt = RUN;
      RUN:          if (done) state_nxt = REPORT;
      default:      state_nxt = IDLE;
    endcase
  end

  // Output decode from state, pointers and live buffer reads.
  always_comb begin
    host_ready      = !rst && (state == IDLE || state == LOAD_KEY ||
                               state == LOAD_MSG || state == REPORT);
    key_valid       = (state == SEND_KEY);
    key_in          = (state == SEND_KEY) ? key_rdata[0] : 8'h00;
    busy            = !(state == IDLE || state == REPORT);
    plain_in_valid  = (state == RUN) && p_avail;
    cipher_in_valid = (state == RUN) && c_avail;
    plain_in        = pbuf_rdata[0];
    cipher_in       = cbuf_rdata[0];
    finish          = finish_q;
    overflow        = ovf_q;
    msg_len         = len_q;
    mismatch_cnt    = mis_q;
  end

  // Session counters, pointers, overflow flag and the finish pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_cnt  <= '0;
      len_q    <= '0;
      p_ptr    <= '0;
      c_ptr    <= '0;
      mis_q    <= '0;
      ovf_q    <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= (state == RUN) && done;
      case (state)
        IDLE, REPORT: begin
          if (host_acc) begin
            key_cnt <= kcnt_t'(1);
            len_q   <= '0;
            p_ptr   <= '0;
            c_ptr   <= '0;
            mis_q   <= '0;
            ovf_q   <= 1'b0;
          end
        end
        LOAD_KEY: begin
          // Wrap to zero on the last key byte so SEND_KEY starts at key[0].
          if (host_acc) key_cnt <= (key_cnt == KEY_LAST) ? '0 : key_cnt + 1'b1;
        end
        LOAD_MSG: begin
          if (host_acc) begin
            if (msg_room) len_q <= len_q + 1'b1;
            else          ovf_q <= 1'b1;
          end
        end
        SEND_KEY: begin
          key_cnt <= key_cnt + 1'b1;
        end
        RUN: begin
          if (cw_acc) p_ptr <= p_ptr + 1'b1;
          if (pw_acc) begin
            c_ptr <= c_ptr + 1'b1;
            if (plain_out != pbuf_rdata[1]) mis_q <= mis_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rc4_host_bridge.sv
// Self-checking bench for rc4_host_bridge: plays host and RC4 core model.
module tb_rc4_host_bridge;
  import rc4_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_valid, host_last, host_ready;
  logic [7:0] host_data;
  logic       key_valid;
  logic [7:0] key_in;
  logic       plain_read, plain_in_valid, cipher_write, cipher_read, cipher_in_valid;
  logic [7:0] plain_in, cipher_out, cipher_in, plain_out;
  logic       plain_write, done, busy, finish, overflow;
  logic [6:0] msg_len, mismatch_cnt;

  rc4_host_bridge dut (
    .clk(clk), .rst(rst),
    .host_valid(host_valid), .host_data(host_data), .host_last(host_last),
    .host_ready(host_ready),
    .key_valid(key_valid), .key_in(key_in),
    .plain_read(plain_read), .plain_in_valid(plain_in_valid), .plain_in(plain_in),
    .cipher_write(cipher_write), .cipher_out(cipher_out),
    .cipher_read(cipher_read), .cipher_in_valid(cipher_in_valid), .cipher_in(cipher_in),
    .plain_write(plain_write), .plain_out(plain_out),
    .done(done), .busy(busy), .finish(finish), .overflow(overflow),
    .msg_len(msg_len), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int    len;      // bytes sent by the host
    byte_t base;     // message byte i = base + i
    int    corrupt;  // recovered byte index the core model flips, -1 for none
    bit    overlap;  // core issues cipher_write and plain_write in the same cycle
    byte_t key_base; // key byte k = key_base + k
    int    exp_len;
    int    exp_mis;
    bit    exp_ovf;
  } vec_t;

  vec_t  vecs [5];
  byte_t key_q  [$];
  byte_t ciph_q [$];
  byte_t exp_plain [MSG_MAX + 4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock; returns just after the falling edge with outputs settled.
  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  // Host loads key and message; bench checks the key replay to the core.
  task automatic load_session(input vec_t v);
    for (int k = 0; k < KEY_LEN; k++) begin
      host_valid = 1'b1;
      host_data  = byte_t'(v.key_base + k);
      host_last  = (k == 5);   // must be ignored during key load
      done       = 1'b1;       // must be ignored outside RUN
      key_q.push_back(byte_t'(v.key_base + k));
      if (k == 0) check("host_ready at start", host_ready, 1);
      cyc();
      if (k == 0) begin
        check("msg_len cleared", msg_len, 0);
        check("mismatch cleared", mismatch_cnt, 0);
        check("overflow cleared", overflow, 0);
        check("busy in load", busy, 1);
      end
    end
    done = 1'b0;
    for (int i = 0; i < v.len; i++) begin
      host_valid = 1'b1;
      host_data  = byte_t'(v.base + i);
      host_last  = (i == v.len - 1);
      if (i < MSG_MAX) begin
        exp_plain[i] = byte_t'(v.base + i);
        ciph_q.push_back(byte_t'(v.base + i) ^ 8'h5A);
      end
      cyc();
    end
    host_valid = 1'b0;
    host_last  = 1'b0;
    // One cycle after the host_last edge the key stream must already be live.
    for (int k = 0; k < KEY_LEN; k++) begin
      byte_t e;
      e = key_q.pop_front();
      check("key_valid", key_valid, 1);
      check("key_in", key_in, e);
      cyc();
    end
    check("key_valid after key", key_valid, 0);
    check("msg_len after load", msg_len, v.exp_len);
    check("overflow after load", overflow, v.exp_ovf);
  endtask

  task automatic run_session(input vec_t v);
    int    n;
    int    cnt;
    byte_t e;
    n = (v.len < MSG_MAX) ? v.len : MSG_MAX;
    load_session(v);
    if (!v.overlap) begin
      cnt = 0;
      for (int g = 0; g < MSG_MAX + 2 && plain_in_valid; g++) begin
        check("plain_in", plain_in, exp_plain[cnt]);
        plain_read = 1'b1;
        cyc();
        plain_read = 1'b0;
        check("plain_in held after read", plain_in, exp_plain[cnt]);
        cipher_write = 1'b1;
        cipher_out   = exp_plain[cnt] ^ 8'h5A;
        cyc();
        cipher_write = 1'b0;
        cnt++;
      end
      check("cipher_write count", cnt, n);
      check("plain_in_valid drop", plain_in_valid, 0);
      cipher_write = 1'b1;
      cipher_out   = 8'hEE;
      cyc();
      cipher_write = 1'b0;
      check("late cipher_write ignored", plain_in_valid, 0);
      cnt = 0;
      for (int g = 0; g < MSG_MAX + 2 && cipher_in_valid; g++) begin
        e = (ciph_q.size() > 0) ? ciph_q.pop_front() : 8'h00;
        check("cipher_in", cipher_in, e);
        cipher_read = 1'b1;
        cyc();
        cipher_read = 1'b0;
        check("cipher_in held after read", cipher_in, e);
        plain_write = 1'b1;
        plain_out   = e ^ 8'h5A ^ ((cnt == v.corrupt) ? 8'h01 : 8'h00);
        cyc();
        plain_write = 1'b0;
        cnt++;
      end
      check("plain_write count", cnt, n);
    end else begin
      // Pipelined core: write cipher byte t while returning recovered byte t-1.
      for (int t = 0; t <= n; t++) begin
        if (t < n) begin
          check("ovl plain_in_valid", plain_in_valid, 1);
          check("ovl plain_in", plain_in, exp_plain[t]);
          cipher_write = 1'b1;
          cipher_out   = exp_plain[t] ^ 8'h5A;
        end
        if (t == 0) check("ovl cipher_in_valid idle", cipher_in_valid, 0);
        else begin
          e = (ciph_q.size() > 0) ? ciph_q.pop_front() : 8'h00;
          check("ovl cipher_in_valid", cipher_in_valid, 1);
          check("ovl cipher_in", cipher_in, e);
          plain_write = 1'b1;
          plain_out   = e ^ 8'h5A ^ ((t - 1 == v.corrupt) ? 8'h01 : 8'h00);
        end
        cyc();
        cipher_write = 1'b0;
        plain_write  = 1'b0;
      end
      check("ovl plain_in_valid drop", plain_in_valid, 0);
    end
    check("cipher_in_valid drop", cipher_in_valid, 0);
    plain_write = 1'b1;
    plain_out   = 8'hFF;
    cyc();
    plain_write = 1'b0;
    check("late plain_write ignored", mismatch_cnt, v.exp_mis);
    check("scoreboard drained", ciph_q.size(), 0);
    check("no early finish", finish, 0);
    done = 1'b1;
    cyc();
    done = 1'b0;
    check("finish pulse", finish, 1);
    check("busy in report", busy, 0);
    check("host_ready in report", host_ready, 1);
    check("msg_len", msg_len, v.exp_len);
    check("mismatch_cnt", mismatch_cnt, v.exp_mis);
    check("overflow", overflow, v.exp_ovf);
    cyc();
    check("finish single cycle", finish, 0);
    check("msg_len held", msg_len, v.exp_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t vr;
    //            len base   corr ovl key    len mis ovf
    vecs[0] = '{  4, 8'h41,  -1, 1'b0, 8'h00,  4,  0, 1'b0}; // "ABCD" -> 1B 18 19 1E
    vecs[1] = '{  4, 8'h41,   1, 1'b0, 8'h80,  4,  1, 1'b0}; // second byte corrupted
    vecs[2] = '{ 70, 8'h10,  -1, 1'b0, 8'h40, 64,  0, 1'b1}; // overflow past 64
    vecs[3] = '{  1, 8'h7E,  -1, 1'b0, 8'h20,  1,  0, 1'b0}; // single byte
    vecs[4] = '{  6, 8'hC0,   3, 1'b1, 8'h60,  6,  1, 1'b0}; // concurrent strobes

    rst = 1'b1;
    host_valid = 1'b0; host_data = 8'h00; host_last = 1'b0;
    plain_read = 1'b0; cipher_write = 1'b0; cipher_out = 8'h00;
    cipher_read = 1'b0; plain_write = 1'b0; plain_out = 8'h00; done = 1'b0;

    cyc();
    check("host_ready in reset", host_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("reset host_ready", host_ready, 1);
    check("reset key_valid", key_valid, 0);
    check("reset key_in", key_in, 0);
    check("reset plain_in_valid", plain_in_valid, 0);
    check("reset cipher_in_valid", cipher_in_valid, 0);
    check("reset busy", busy, 0);
    check("reset finish", finish, 0);
    check("reset overflow", overflow, 0);
    check("reset msg_len", msg_len, 0);
    check("reset mismatch_cnt", mismatch_cnt, 0);

    for (int i = 0; i < 5; i++) run_session(vecs[i]);

    // Abort in RUN at byte 2 of an overflowed session.
    vr = '{66, 8'h30, -1, 1'b0, 8'hA0, 64, 0, 1'b1};
    load_session(vr);
    for (int t = 0; t < 2; t++) begin
      cipher_write = 1'b1;
      cipher_out   = exp_plain[t] ^ 8'h5A;
      cyc();
    end
    cipher_write = 1'b0;
    check("pre-abort busy", busy, 1);
    check("pre-abort plain_in_valid", plain_in_valid, 1);
    check("pre-abort overflow", overflow, 1);
    rst = 1'b1;
    #1;
    check("abort host_ready in reset", host_ready, 0);
    cyc();
    rst = 1'b0;
    #1;
    check("abort busy", busy, 0);
    check("abort host_ready", host_ready, 1);
    check("abort key_valid", key_valid, 0);
    check("abort key_in", key_in, 0);
    check("abort plain_in_valid", plain_in_valid, 0);
    check("abort cipher_in_valid", cipher_in_valid, 0);
    check("abort finish", finish, 0);
    check("abort overflow", overflow, 0);
    check("abort msg_len", msg_len, 0);
    check("abort mismatch_cnt", mismatch_cnt, 0);
    ciph_q.delete();
    key_q.delete();

    // Fresh session from IDLE after the abort.
    run_session(vecs[1]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
